// File: rtl/maxnet_pkg.sv
// Shared constants, FSM state encoding and activation helpers for the Maxnet controller.
package maxnet_pkg;

    localparam int unsigned DW      = 32;
    localparam int unsigned N_LANES = 4;
    localparam int unsigned ROW_W   = 2;
    localparam int unsigned NZ_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_NEXT,
        ST_UPDATE,
        ST_CHECK,
        ST_DONE
    } state_e;

    // ReLU on the PLU word: sign bit set means the result is dropped to zero.
    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction

    // Magnitude test only, so a negative zero is treated as zero.
    function automatic logic is_nonzero(input logic [DW-1:0] x);
        return |x[DW-2:0];
    endfunction

endpackage

// File: rtl/maxnet_act_bank.sv
// Current and next activation banks: ReLU write port, bulk update, nonzero count and winner encode.
module maxnet_act_bank
    import maxnet_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [N_LANES*DW-1:0]   load_data,
    input  logic                    wr_en,
    input  logic [ROW_W-1:0]        wr_idx,
    input  logic [DW-1:0]           wr_data,
    input  logic                    update,
    output logic [N_LANES*DW-1:0]   act,
    output logic [NZ_W-1:0]         nz_count_c,
    output logic [ROW_W-1:0]        winner_c
);

    logic [DW-1:0] act_q  [N_LANES];
    logic [DW-1:0] next_q [N_LANES];

    // next_q collects one row result per job; act_q only moves on the update strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_LANES); i++) begin
                act_q[i]  <= '0;
                next_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < int'(N_LANES); i++) begin
                act_q[i]  <= load_data[i*DW +: DW];
                next_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                next_q[wr_idx] <= relu(wr_data);
            end
            if (update) begin
                for (int i = 0; i < int'(N_LANES); i++) begin
                    act_q[i] <= next_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < int'(N_LANES); g++) begin : g_act
        assign act[g*DW +: DW] = act_q[g];
    end

    // Scan from the top lane down so the lowest nonzero index is the last one written.
    always_comb begin
        nz_count_c = '0;
        winner_c   = '0;
        for (int i = int'(N_LANES) - 1; i >= 0; i--) begin
            if (is_nonzero(act_q[i])) begin
                nz_count_c = nz_count_c + NZ_W'(1);
                winner_c   = ROW_W'(i);
            end
        end
    end

endmodule

// File: rtl/maxnet_ctrl.sv
// Maxnet competition controller: drives one PLU row job at a time until at most one activation survives.
module maxnet_ctrl
    import maxnet_pkg::*;
#(
    parameter int unsigned MAX_ITER = 64,
    parameter int unsigned IW       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [16*DW-1:0]        w_mat,
    input  logic [N_LANES*DW-1:0]   a_init,
    output logic                    busy,
    output logic                    done,
    output logic [ROW_W-1:0]        winner,
    output logic                    no_winner,
    output logic                    timeout,
    output logic [IW-1:0]           iter_count,
    output logic                    err_overflow,
    output logic [N_LANES*DW-1:0]   a_out,
    output logic                    plu_start,
    output logic [N_LANES*DW-1:0]   plu_w,
    output logic [N_LANES*DW-1:0]   plu_a,
    input  logic [DW-1:0]           plu_out,
    input  logic                    plu_done,
    input  logic                    plu_overflow
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_LANES - 1);

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [IW-1:0]           iter_d;
    logic [16*DW-1:0]        w_q, w_src;
    logic [N_LANES*DW-1:0]   plu_w_d;
    logic                    busy_d, done_d, plu_start_d, timeout_d, err_d, no_winner_d;
    logic [ROW_W-1:0]        winner_d;
    logic                    load_c, wr_en_c, update_c;
    logic [NZ_W-1:0]         nz_count_c;
    logic [ROW_W-1:0]        win_c;

    maxnet_act_bank u_bank (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .load_data  (a_init),
        .wr_en      (wr_en_c),
        .wr_idx     (row_q),
        .wr_data    (plu_out),
        .update     (update_c),
        .act        (a_out),
        .nz_count_c (nz_count_c),
        .winner_c   (win_c)
    );

    // Activations only change on UPDATE, so they double as the PLU a-lanes.
    assign plu_a = a_out;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        iter_d      = iter_count;
        timeout_d   = timeout;
        err_d       = err_overflow;
        winner_d    = winner;
        no_winner_d = no_winner;
        load_c      = 1'b0;
        wr_en_c     = 1'b0;
        update_c    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_c      = 1'b1;
                    row_d       = '0;
                    iter_d      = '0;
                    timeout_d   = 1'b0;
                    err_d       = 1'b0;
                    winner_d    = '0;
                    no_winner_d = 1'b0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT_LO;
            // A done level left over from the previous job must drop before a new capture.
            ST_WAIT_LO: begin
                if (!plu_done) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (plu_done) begin
                    wr_en_c = 1'b1;
                    err_d   = err_overflow | plu_overflow;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (row_q == LAST_ROW) begin
                    state_d = ST_UPDATE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_UPDATE: begin
                update_c = 1'b1;
                iter_d   = iter_count + IW'(1);
                row_d    = '0;
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                if (nz_count_c <= NZ_W'(1)) begin
                    state_d = ST_DONE;
                end else if (iter_count == IW'(MAX_ITER)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_CHECK && state_d == ST_DONE) begin
            winner_d    = win_c;
            no_winner_d = (nz_count_c == '0);
        end

        plu_start_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
    end

    // Row mux; on the accepting cycle the weights come straight from the input bus.
    always_comb begin
        w_src   = load_c ? w_mat : w_q;
        plu_w_d = plu_w;
        if (state_d == ST_ISSUE) begin
            for (int i = 0; i < int'(N_LANES); i++) begin
                plu_w_d[i*DW +: DW] = w_src[(int'(row_d)*int'(N_LANES) + i)*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            iter_count   <= '0;
            w_q          <= '0;
            plu_start    <= 1'b0;
            plu_w        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            err_overflow <= 1'b0;
            winner       <= '0;
            no_winner    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            iter_count   <= iter_d;
            if (load_c) begin
                w_q <= w_mat;
            end
            plu_start    <= plu_start_d;
            plu_w        <= plu_w_d;
            busy         <= busy_d;
            done         <= done_d;
            timeout      <= timeout_d;
            err_overflow <= err_d;
            winner       <= winner_d;
            no_winner    <= no_winner_d;
        end
    end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Bench for maxnet_ctrl: behavioural PLU (latency 5, level done), scoreboard of run and iteration results.
module tb_maxnet_ctrl;
    import maxnet_pkg::*;

    localparam int unsigned IW     = 8;
    localparam int          LAT    = 5;
    localparam int          BUDGET = 3000;

    typedef struct {
        logic [4*DW-1:0] a;
        logic [1:0]      winner;
        logic            no_w;
        logic            tmo;
        logic            ovf;
        logic [IW-1:0]   iter;
        int              pulses;
    } res_t;

    typedef struct {
        logic [IW-1:0]   iter;
        logic [4*DW-1:0] a;
    } it_t;

    res_t exp_q[$];
    it_t  it_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              d0_start = 1'b0, d1_start = 1'b0;
    logic [16*DW-1:0]  d0_w_mat = '0, d1_w_mat = '0;
    logic [4*DW-1:0]   d0_a_init = '0, d1_a_init = '0;
    logic              d0_busy, d0_done, d0_no_w, d0_tmo, d0_err, d0_plu_start;
    logic              d1_busy, d1_done, d1_no_w, d1_tmo, d1_err, d1_plu_start;
    logic [1:0]        d0_winner, d1_winner;
    logic [IW-1:0]     d0_iter, d1_iter;
    logic [4*DW-1:0]   d0_a_out, d0_plu_w, d0_plu_a, d1_a_out, d1_plu_w, d1_plu_a;
    logic [DW-1:0]     d0_plu_out, d1_plu_out;
    logic              d0_plu_done, d0_plu_ovf, d1_plu_done, d1_plu_ovf;

    maxnet_ctrl #(.MAX_ITER(64), .IW(IW)) u_dut0 (
        .clk(clk), .rst(rst), .start(d0_start), .w_mat(d0_w_mat), .a_init(d0_a_init),
        .busy(d0_busy), .done(d0_done), .winner(d0_winner), .no_winner(d0_no_w),
        .timeout(d0_tmo), .iter_count(d0_iter), .err_overflow(d0_err), .a_out(d0_a_out),
        .plu_start(d0_plu_start), .plu_w(d0_plu_w), .plu_a(d0_plu_a),
        .plu_out(d0_plu_out), .plu_done(d0_plu_done), .plu_overflow(d0_plu_ovf)
    );

    maxnet_ctrl #(.MAX_ITER(4), .IW(IW)) u_dut1 (
        .clk(clk), .rst(rst), .start(d1_start), .w_mat(d1_w_mat), .a_init(d1_a_init),
        .busy(d1_busy), .done(d1_done), .winner(d1_winner), .no_winner(d1_no_w),
        .timeout(d1_tmo), .iter_count(d1_iter), .err_overflow(d1_err), .a_out(d1_a_out),
        .plu_start(d1_plu_start), .plu_w(d1_plu_w), .plu_a(d1_plu_a),
        .plu_out(d1_plu_out), .plu_done(d1_plu_done), .plu_overflow(d1_plu_ovf)
    );

    function automatic logic [DW-1:0] dot(input logic [4*DW-1:0] w, input logic [4*DW-1:0] a);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) s = s + w[i*DW +: DW] * a[i*DW +: DW];
        return s;
    endfunction

    function automatic logic [4*DW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    function automatic logic [16*DW-1:0] wmat();
        logic [16*DW-1:0] m;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                m[(4*j+i)*DW +: DW] = (i == j) ? DW'(4) : DW'(-1);
        return m;
    endfunction

    function automatic res_t mk_res(input logic [4*DW-1:0] a, input int win, input bit no_w,
                                    input bit tmo, input bit ovf, input int iter, input int pulses);
        res_t r;
        r.a = a; r.winner = 2'(win); r.no_w = no_w; r.tmo = tmo; r.ovf = ovf;
        r.iter = IW'(iter); r.pulses = pulses;
        return r;
    endfunction

    function automatic it_t mk_it(input int iter, input logic [4*DW-1:0] a);
        it_t t;
        t.iter = IW'(iter); t.a = a;
        return t;
    endfunction

    // Behavioural PLUs: two's-complement dot product, done level held until the next job.
    int jobs0 = 0;
    int ovf_job0 = -1;
    int cnt0, cnt1;
    logic [DW-1:0] acc0, acc1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d0_plu_done <= 1'b0; d0_plu_out <= '0; d0_plu_ovf <= 1'b0; cnt0 <= 0; acc0 <= '0;
        end else if (d0_plu_start) begin
            d0_plu_done <= 1'b0; d0_plu_ovf <= 1'b0; cnt0 <= LAT;
            acc0 <= dot(d0_plu_w, d0_plu_a); jobs0 <= jobs0 + 1;
        end else if (cnt0 > 0) begin
            cnt0 <= cnt0 - 1;
            if (cnt0 == 1) begin
                d0_plu_done <= 1'b1; d0_plu_out <= acc0; d0_plu_ovf <= (jobs0 == ovf_job0);
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d1_plu_done <= 1'b0; d1_plu_out <= '0; d1_plu_ovf <= 1'b0; cnt1 <= 0; acc1 <= '0;
        end else if (d1_plu_start) begin
            d1_plu_done <= 1'b0; d1_plu_ovf <= 1'b0; cnt1 <= LAT; acc1 <= dot(d1_plu_w, d1_plu_a);
        end else if (cnt1 > 0) begin
            cnt1 <= cnt1 - 1;
            if (cnt1 == 1) begin
                d1_plu_done <= 1'b1; d1_plu_out <= acc1;
            end
        end
    end

    // Scoreboard monitor for instance 0: per-iteration activations and end-of-run results.
    initial begin : mon0
        logic pb, pd;
        logic [IW-1:0] pi;
        int pc;
        res_t e;
        it_t t;
        pb = 1'b0; pd = 1'b0; pi = '0; pc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pb = 1'b0; pd = 1'b0; pi = '0; pc = 0;
            end else begin
                if (d0_busy && !pb) pc = 0;
                if (d0_plu_start) pc++;
                if (d0_iter == IW'(pi + 1'b1)) begin
                    vectors++;
                    if (it_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL iter_unexpected: iter_count=%0d, none expected", d0_iter);
                    end else begin
                        t = it_q.pop_front();
                        if (d0_iter !== t.iter || d0_a_out !== t.a) begin
                            miscompares++;
                            $display("FAIL iter_act: iter=%0d a_out=%h, want iter=%0d a_out=%h",
                                     d0_iter, d0_a_out, t.iter, t.a);
                        end
                    end
                end
                if (d0_done && !pd) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL done_unexpected: done rose with no run expected");
                    end else begin
                        e = exp_q.pop_front();
                        if (d0_a_out !== e.a) begin
                            miscompares++;
                            $display("FAIL run_a_out: got %h want %h", d0_a_out, e.a);
                        end
                        vectors++;
                        if (d0_winner !== e.winner || d0_no_w !== e.no_w || d0_tmo !== e.tmo) begin
                            miscompares++;
                            $display("FAIL run_flags: winner/no_winner/timeout got %0d/%0b/%0b want %0d/%0b/%0b",
                                     d0_winner, d0_no_w, d0_tmo, e.winner, e.no_w, e.tmo);
                        end
                        vectors++;
                        if (d0_iter !== e.iter || d0_err !== e.ovf || d0_busy !== 1'b0) begin
                            miscompares++;
                            $display("FAIL run_status: iter/err/busy got %0d/%0b/%0b want %0d/%0b/0",
                                     d0_iter, d0_err, d0_busy, e.iter, e.ovf);
                        end
                        vectors++;
                        if (pc !== e.pulses) begin
                            miscompares++;
                            $display("FAIL run_pulses: plu_start pulses got %0d want %0d", pc, e.pulses);
                        end
                    end
                end
                pb = d0_busy; pd = d0_done; pi = d0_iter;
            end
        end
    end

    task automatic run0(input logic [4*DW-1:0] a, input bit poke);
        int n;
        d0_w_mat  = wmat();
        d0_a_init = a;
        d0_start  = 1'b1;
        @(negedge clk);
        d0_start = 1'b0;
        n = 0;
        while (!d0_done && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (poke && n == 10) begin
                vectors++;
                if (d0_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL poke_busy: busy got %0b want 1", d0_busy);
                end
                d0_a_init = '0;
                d0_start  = 1'b1;
            end else begin
                d0_start = 1'b0;
            end
        end
        d0_start = 1'b0;
        vectors++;
        if (d0_done !== 1'b1) begin
            miscompares++;
            $display("FAIL run_wait: done got %0b want 1 within %0d cycles", d0_done, BUDGET);
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(negedge clk);
        vectors++;
        if ({d0_busy, d0_done, d0_plu_start, d0_err, d0_tmo} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy,done,plu_start,err,timeout got %b want 00000",
                     {d0_busy, d0_done, d0_plu_start, d0_err, d0_tmo});
        end
        vectors++;
        if (d0_iter !== '0 || d0_a_out !== '0 || d0_plu_w !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: iter=%0d a_out=%h plu_w=%h want all 0", d0_iter, d0_a_out, d0_plu_w);
        end
        rst = 1'b1;
        @(negedge clk);
        d0_w_mat  = wmat();
        d0_a_init = pack4(10, 8, 3, 1);
        d0_start  = 1'b1;
        @(negedge clk);
        d0_start = 1'b0;
        n = 0;
        while (!d0_plu_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (d0_plu_start !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_issue: plu_start got %0b want 1", d0_plu_start);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (d0_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy: busy got %0b want 1 before reset", d0_busy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({d0_plu_start, d0_busy, d0_done} !== 3'b0 || d0_iter !== '0 || d0_a_out !== '0) begin
            miscompares++;
            $display("FAIL abort_reset: plu_start,busy,done=%b iter=%0d a_out=%h want 0",
                     {d0_plu_start, d0_busy, d0_done}, d0_iter, d0_a_out);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_winner();
        exp_q.push_back(mk_res(pack4(0, 20, 0, 0), 1, 1'b0, 1'b0, 1'b0, 1, 4));
        it_q.push_back(mk_it(1, pack4(0, 20, 0, 0)));
        run0(pack4(0, 5, 0, 0), 1'b0);
    endtask

    task automatic test_convergence();
        exp_q.push_back(mk_res(pack4(1246, 0, 0, 0), 0, 1'b0, 1'b0, 1'b0, 4, 16));
        it_q.push_back(mk_it(1, pack4(28, 18, 0, 0)));
        it_q.push_back(mk_it(2, pack4(94, 44, 0, 0)));
        it_q.push_back(mk_it(3, pack4(332, 82, 0, 0)));
        it_q.push_back(mk_it(4, pack4(1246, 0, 0, 0)));
        run0(pack4(10, 8, 3, 1), 1'b0);
    endtask

    task automatic test_overflow_busy_start();
        ovf_job0 = jobs0 + 3;
        exp_q.push_back(mk_res(pack4(0, 20, 0, 0), 1, 1'b0, 1'b0, 1'b1, 1, 4));
        it_q.push_back(mk_it(1, pack4(0, 20, 0, 0)));
        run0(pack4(0, 5, 0, 0), 1'b1);
        ovf_job0 = -1;
    endtask

    task automatic test_all_zero();
        exp_q.push_back(mk_res('0, 0, 1'b1, 1'b0, 1'b0, 1, 4));
        it_q.push_back(mk_it(1, '0));
        run0('0, 1'b0);
    endtask

    task automatic test_timeout();
        int n;
        d1_w_mat  = wmat();
        d1_a_init = pack4(5, 5, 0, 0);
        d1_start  = 1'b1;
        @(negedge clk);
        d1_start = 1'b0;
        n = 0;
        while (!d1_done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (d1_done !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_wait: done got %0b want 1", d1_done);
        end
        vectors++;
        if (d1_a_out !== pack4(405, 405, 0, 0)) begin
            miscompares++;
            $display("FAIL timeout_a_out: got %h want %h", d1_a_out, pack4(405, 405, 0, 0));
        end
        vectors++;
        if (d1_tmo !== 1'b1 || d1_iter !== IW'(4) || d1_winner !== 2'd0 || d1_no_w !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_flags: timeout/iter/winner/no_winner got %0b/%0d/%0d/%0b want 1/4/0/0",
                     d1_tmo, d1_iter, d1_winner, d1_no_w);
        end
    endtask

    initial begin
        test_reset();
        test_single_winner();
        test_convergence();
        test_overflow_busy_start();
        test_all_zero();
        test_timeout();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0 || it_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d runs and %0d iterations left, want 0",
                     exp_q.size(), it_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
